bcd_sub_serial: RTL and testbench

Digit-serial packed-BCD subtractor: computes D = A - B - Bin over DIGITS BCD digits, one digit per clock, LSD first, with ten's-complement borrow correction. It is the subtract-side counterpart of the team's combinational BCD adder and sits beside it in the decimal arithmetic datapath. The block has a start/ready/done handshake and holds its result until the next operation is accepted.

---
 rtl/bcd_pkg.sv | 7 +
 rtl/bcd_sub_serial_if.sv | 14 +
 rtl/bcd_digit_sub.sv | 21 ++
 rtl/bcd_sub_serial.sv | 95 +++++++++
 tb/tb_bcd_sub_serial.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, digit type and FSM states for the decimal datapath
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX = 9;
    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} bcd_sub_state_t;
endpackage

// File: rtl/bcd_sub_serial_if.sv
// bcd_sub_serial_if: start/ready/done handshake and operand/result bus of the serial BCD subtractor
interface bcd_sub_serial_if #(parameter int DIGITS = 2);
    logic start;
    logic [4*DIGITS-1:0] A;
    logic [4*DIGITS-1:0] B;
    logic Bin;
    logic ready;
    logic done;
    logic [4*DIGITS-1:0] D;
    logic Bout;
    logic err;
    modport master (output start, A, B, Bin, input ready, done, D, Bout, err);
    modport slave (input start, A, B, Bin, output ready, done, D, Bout, err);
endinterface

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: combinational single BCD digit subtract with borrow and invalid-digit flag
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout,
    output logic       inv
);
    logic [4:0] t;
    logic [4:0] adj;
    always_comb begin
        t = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        adj = t + 5'd10;
        bout = t[4];
        d = bout ? adj[3:0] : t[3:0];
        inv = (a > bcd_digit_t'(BCD_MAX)) || (b > bcd_digit_t'(BCD_MAX));
    end
endmodule

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial packed-BCD subtractor D = A - B - Bin, one digit per clock, LSD first
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input logic clk,
    input logic rst,
    bcd_sub_serial_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    bcd_sub_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    bcd_digit_t [DIGITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic borrow_q, borrow_d, inv_q, inv_d, bout_q, bout_d, err_q, err_d;
    bcd_digit_t dig_d;
    logic dig_bout, dig_inv, last;
    bcd_digit_sub u_dig (
        .a(a_q[idx_q]),
        .b(b_q[idx_q]),
        .bin(borrow_q),
        .d(dig_d),
        .bout(dig_bout),
        .inv(dig_inv)
    );
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        a_d = a_q;
        b_d = b_q;
        res_d = res_q;
        borrow_d = borrow_q;
        inv_d = inv_q;
        d_d = d_q;
        bout_d = bout_q;
        err_d = err_q;
        last = idx_q == IW'(DIGITS - 1);
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                idx_d = '0;
                a_d = bus.A;
                b_d = bus.B;
                res_d = '0;
                borrow_d = bus.Bin;
                inv_d = 1'b0;
            end
            RUN: begin
                res_d[idx_q] = dig_d;
                borrow_d = dig_bout;
                inv_d = inv_q | dig_inv;
                idx_d = idx_q + 1'b1;
                // results publish atomically on the edge entering DONE; an invalid digit forces a zero result
                if (last) begin
                    state_d = DONE;
                    d_d = inv_d ? '0 : res_d;
                    bout_d = !inv_d && dig_bout;
                    err_d = inv_d;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            borrow_q <= 1'b0;
            inv_q <= 1'b0;
            d_q <= '0;
            bout_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            borrow_q <= borrow_d;
            inv_q <= inv_d;
            d_q <= d_d;
            bout_q <= bout_d;
            err_q <= err_d;
        end
    end
    assign bus.ready = state_q == IDLE;
    assign bus.done = state_q == DONE;
    assign bus.D = d_q;
    assign bus.Bout = bout_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: directed and randomized checks of bcd_sub_serial against a decimal-arithmetic model
module tb_bcd_sub_serial;
    localparam int DIGITS = 2;
    localparam int W = 4 * DIGITS;
    typedef struct {logic [W-1:0] d; logic bo; logic e;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    exp_t q[$];
    bcd_sub_serial_if #(.DIGITS(DIGITS)) bus ();
    bcd_sub_serial #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t r;
        int av = 0, bv = 0, diff, p = 1;
        logic [3:0] na, nb;
        r.e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            na = a[i*4 +: 4];
            nb = b[i*4 +: 4];
            if (na > 9 || nb > 9) r.e = 1'b1;
            av = av * 10 + int'(na);
            bv = bv * 10 + int'(nb);
            p = p * 10;
        end
        diff = av - bv - int'(bin);
        r.bo = diff < 0;
        if (r.bo) diff += p;
        r.d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r.d[i*4 +: 4] = 4'(diff % 10);
            diff = diff / 10;
        end
        if (r.e) begin
            r.d = '0;
            r.bo = 1'b0;
        end
        return r;
    endfunction
    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[i*4 +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return v;
    endfunction
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t x;
        logic [W-1:0] d0;
        int n;
        x = model(a, b, bin);
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
        bus.Bin = 1'($urandom);
        d0 = bus.D;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("ready_done_excl", 32'(bus.ready & bus.done), 32'd0);
            if (!bus.done) chk("d_hold_run", 32'(bus.D), 32'(d0));
        end while (!bus.done && n < 20);
        chk("latency", 32'(n), 32'(DIGITS + 1));
        chk("D", 32'(bus.D), 32'(x.d));
        chk("Bout", 32'(bus.Bout), 32'(x.bo));
        chk("err", 32'(bus.err), 32'(x.e));
        @(negedge clk);
        chk("ready_back", 32'(bus.ready), 32'd1);
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask
    task automatic hold_test(input int cycles);
        int low = 0;
        logic [W-1:0] last_d;
        exp_t x;
        last_d = bus.D;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (q.size() == 0) chk("hold_unexpected_done", 32'd1, 32'd0);
                else begin
                    x = q.pop_front();
                    chk("hold_D", 32'(bus.D), 32'(x.d));
                    chk("hold_Bout", 32'(bus.Bout), 32'(x.bo));
                    chk("hold_err", 32'(bus.err), 32'(x.e));
                end
                last_d = bus.D;
            end else if (!bus.ready) chk("hold_d_stable", 32'(bus.D), 32'(last_d));
            if (!bus.ready) low++;
            else begin
                if (low > 0) chk("ready_low_len", 32'(low), 32'(DIGITS + 1));
                low = 0;
            end
            bus.start = c < cycles - 1;
            bus.A = rand_bcd();
            bus.B = rand_bcd();
            bus.Bin = 1'($urandom);
            if (bus.start && bus.ready) q.push_back(model(bus.A, bus.B, bus.Bin));
        end
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
            if (bus.done) begin
                x = q.pop_front();
                chk("drain_D", 32'(bus.D), 32'(x.d));
                chk("drain_Bout", 32'(bus.Bout), 32'(x.bo));
                chk("drain_err", 32'(bus.err), 32'(x.e));
            end
        end
        chk("hold_drain", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int dones;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_D", 32'(bus.D), 32'd0);
        chk("rst_Bout", 32'(bus.Bout), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_op(8'h42, 8'h17, 1'b0);
        run_op(8'h17, 8'h42, 1'b0);
        run_op(8'h50, 8'h09, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'h37, 8'h37, 1'b0);
        run_op(8'h1A, 8'h03, 1'b0);
        run_op(8'h10, 8'h01, 1'b0);
        bus.start = 1'b1;
        bus.A = 8'h42;
        bus.B = 8'h17;
        bus.Bin = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.ready), 32'd1);
        chk("arst_D", 32'(bus.D), 32'd0);
        chk("arst_Bout", 32'(bus.Bout), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("no_done_after_rst", 32'(dones), 32'd0);
        run_op(8'h99, 8'h01, 1'b0);
        hold_test(40);
        for (int k = 0; k < 30; k++) run_op(rand_bcd(), rand_bcd(), 1'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
